// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM for the iterative AES-128 encrypt core.
// Sequences init load, NR rounds of ROUND_LAT cycles, and result handshake.
module aes_round_sequencer #(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic       st_load,
  output logic       key_load,
  output logic       key_step,
  output logic       rnd_en,
  output logic       skip_mix,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ROUND,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] round_nx;
  logic [7:0] rcon_nx;
  logic [3:0] lat_cnt;
  logic [3:0] lat_nx;
  logic       last_lat;
  logic       last_rnd;

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign last_lat = (lat_cnt == 4'(ROUND_LAT - 1));
  assign last_rnd = (round == 4'(NR));

  // State, round index, round constant and per-round cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      round   <= 4'd0;
      rcon    <= 8'h01;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_nx;
      round   <= round_nx;
      rcon    <= rcon_nx;
      lat_cnt <= lat_nx;
    end
  end

  // Next-state and datapath strobes; abort wins over everything and
  // suppresses the strobes of the cycle in which it is seen.
  always_comb begin
    state_nx  = state;
    round_nx  = round;
    rcon_nx   = rcon;
    lat_nx    = lat_cnt;
    in_ready  = 1'b0;
    st_load   = 1'b0;
    key_load  = 1'b0;
    key_step  = 1'b0;
    rnd_en    = 1'b0;
    skip_mix  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) state_nx = INIT;
      end
      INIT: begin
        st_load  = !abort;
        key_load = !abort;
        state_nx = ROUND;
        round_nx = 4'd1;
        rcon_nx  = 8'h01;
        lat_nx   = 4'd0;
      end
      ROUND: begin
        skip_mix = last_rnd;
        key_step = (lat_cnt == 4'd0) && !abort;
        rnd_en   = last_lat && !abort;
        if (last_lat) begin
          if (last_rnd) begin
            state_nx = DONE;
          end else begin
            round_nx = round + 4'd1;
            rcon_nx  = xtime(rcon);
            lat_nx   = 4'd0;
          end
        end else begin
          lat_nx = lat_cnt + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
          round_nx = 4'd0;
          rcon_nx  = 8'h01;
          lat_nx   = 4'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      round_nx = 4'd0;
      rcon_nx  = 8'h01;
      lat_nx   = 4'd0;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed bench for the AES round sequencer.
// Instance a uses defaults; instance b uses NR=2, ROUND_LAT=1.
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_in_valid, a_abort, a_out_ready;
  logic       a_in_ready, a_st_load, a_key_load;
  logic       a_key_step, a_rnd_en, a_skip_mix;
  logic [3:0] a_round;
  logic [7:0] a_rcon;
  logic       a_out_valid, a_busy;
  logic       b_in_valid, b_abort, b_out_ready;
  logic       b_in_ready, b_st_load, b_key_load;
  logic       b_key_step, b_rnd_en, b_skip_mix;
  logic [3:0] b_round;
  logic [7:0] b_rcon;
  logic       b_out_valid, b_busy;

  aes_round_sequencer u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .abort(a_abort),
    .st_load(a_st_load), .key_load(a_key_load),
    .key_step(a_key_step), .rnd_en(a_rnd_en),
    .skip_mix(a_skip_mix),
    .round(a_round), .rcon(a_rcon),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .busy(a_busy)
  );

  aes_round_sequencer #(.NR(2), .ROUND_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .abort(b_abort),
    .st_load(b_st_load), .key_load(b_key_load),
    .key_step(b_key_step), .rnd_en(b_rnd_en),
    .skip_mix(b_skip_mix),
    .round(b_round), .rcon(b_rcon),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy)
  );

  int errs   = 0;
  int checks = 0;

  logic [7:0] rc_tbl [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One block on instance a, consumer stalls `hold` cycles in DONE.
  task automatic run_a(input int hold);
    int k;
    a_in_valid = 1'b1;
    #1;
    chk("req_ready", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    for (int c = 1; c <= 32 + hold; c++) begin
      a_out_ready = (c == 32 + hold);
      #1;
      chk("st_load", a_st_load, c == 1);
      chk("key_load", a_key_load, c == 1);
      chk("rnd_en", a_rnd_en,
          c >= 4 && c <= 31 && (c - 4) % 3 == 0);
      chk("key_step", a_key_step,
          c >= 2 && c <= 29 && (c - 2) % 3 == 0);
      chk("skip_mix", a_skip_mix, c >= 29 && c <= 31);
      chk("out_valid", a_out_valid, c >= 32);
      chk("in_ready", a_in_ready, 0);
      chk("busy", a_busy, 1);
      if (c >= 2 && c <= 29 && (c - 2) % 3 == 0) begin
        k = (c - 2) / 3;
        chk("rcon", a_rcon, rc_tbl[k]);
        chk("round", a_round, k + 1);
      end
      tick();
    end
    a_out_ready = 1'b0;
    #1;
    chk("post_ready", a_in_ready, 1);
    chk("post_busy", a_busy, 0);
    chk("post_round", a_round, 0);
    chk("post_ovalid", a_out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_abort = 0; a_out_ready = 0;
    b_in_valid = 0; b_abort = 0; b_out_ready = 0;
    #12;
    chk("rst_ready", a_in_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_round", a_round, 0);
    chk("rst_rcon", a_rcon, 8'h01);
    chk("rst_ovalid", a_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // async reset mid-block, round 5
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (14) tick();
    chk("r5_round", a_round, 5);
    chk("r5_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_ready", a_in_ready, 1);
    chk("arst_round", a_round, 0);
    chk("arst_rcon", a_rcon, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // nominal block with 5 cycles of backpressure
    run_a(5);

    // abort at round 3, lat_cnt 1
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (8) tick();
    a_abort = 1'b1;
    #1;
    chk("ab_round", a_round, 3);
    chk("ab_kstep", a_key_step, 0);
    chk("ab_rnd", a_rnd_en, 0);
    tick();
    a_abort = 1'b0;
    #1;
    chk("ab_busy", a_busy, 0);
    chk("ab_ready", a_in_ready, 1);
    chk("ab_round0", a_round, 0);
    chk("ab_rcon", a_rcon, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_quiet_r", a_rnd_en, 0);
      chk("ab_quiet_k", a_key_step, 0);
    end
    run_a(0);

    // abort in IDLE is ignored
    a_abort = 1'b1;
    #1;
    chk("idle_ab_ready", a_in_ready, 1);
    tick();
    a_abort = 1'b0;
    #1;
    chk("idle_ab_busy", a_busy, 0);

    // abort beats out_ready in DONE; in_valid held
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (31) tick();
    chk("d_ovalid", a_out_valid, 1);
    a_abort = 1'b1;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    #1;
    chk("d_ready", a_in_ready, 0);
    tick();
    a_abort = 1'b0;
    a_out_ready = 1'b0;
    #1;
    chk("d_busy", a_busy, 0);
    chk("d_idle_ready", a_in_ready, 1);
    chk("d_ovalid0", a_out_valid, 0);
    tick();
    chk("d_accept", a_st_load, 1);
    a_in_valid = 1'b0;
    a_abort = 1'b1;
    #1;
    chk("init_ab_ld", a_st_load, 0);
    chk("init_ab_kl", a_key_load, 0);
    tick();
    a_abort = 1'b0;
    #1;
    chk("init_ab_busy", a_busy, 0);

    // NR=2, ROUND_LAT=1
    b_in_valid = 1'b1;
    #1;
    chk("b_ready", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0;
    #1;
    chk("b_st_load", b_st_load, 1);
    chk("b_key_load", b_key_load, 1);
    tick();
    chk("b_r1_k", b_key_step, 1);
    chk("b_r1_r", b_rnd_en, 1);
    chk("b_r1_rc", b_rcon, 8'h01);
    chk("b_r1_rd", b_round, 1);
    chk("b_r1_sm", b_skip_mix, 0);
    chk("b_r1_ov", b_out_valid, 0);
    tick();
    chk("b_r2_k", b_key_step, 1);
    chk("b_r2_r", b_rnd_en, 1);
    chk("b_r2_rc", b_rcon, 8'h02);
    chk("b_r2_rd", b_round, 2);
    chk("b_r2_sm", b_skip_mix, 1);
    chk("b_r2_ov", b_out_valid, 0);
    tick();
    b_out_ready = 1'b1;
    #1;
    chk("b_ov", b_out_valid, 1);
    chk("b_done_sm", b_skip_mix, 0);
    chk("b_done_r", b_rnd_en, 0);
    tick();
    b_out_ready = 1'b0;
    #1;
    chk("b_idle", b_in_ready, 1);
    chk("b_busy", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
